// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline types and constants
//
// Purpose: ALUOp encodings and the ID/EX control bundle shared by the
// decode, ID/EX register and execute stages.
// Ports: none (package).
package riscv_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;  // LW/SW/AUIPC: ALU adds
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RI     = 2'b10;  // R/I-type: funct3/funct7 decide
  localparam logic [1:0] ALUOP_JLUI   = 2'b11;  // JAL/LUI

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } id_ex_ctrl_t;

  // A bubble decodes as a harmless ADD with every side effect disabled.
  localparam id_ex_ctrl_t ID_EX_CTRL_BUBBLE = '{alu_op: ALUOP_MEM, default: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for performance monitoring
//
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset, clears count
//   inc    in  count one event this cycle
//   count  out W-bit registered count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with stall, flush and bubble count
//
// Purpose: captures decoded operands and control from ID for the EX stage.
// Priority per edge: reset > flush > stall > load. A flush, or a load while
// ID is empty, inserts an all-zero bubble and bumps bubble_count.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall, flush          hold EX / replace EX with a bubble
//   id_*                  decoded instruction fields from ID
//   ex_*                  registered copies presented to EX
//   bubble_count          saturating count of inserted bubbles
module id_ex_stage_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_branch,
  input  logic             id_jump,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [CNT_W-1:0] bubble_count
);

  id_ex_ctrl_t id_ctrl;
  id_ex_ctrl_t ex_ctrl;
  logic        insert_bubble;
  logic        load;

  assign id_ctrl = '{alu_op:     id_alu_op,
                     alu_src:    id_alu_src,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     reg_write:  id_reg_write,
                     mem_to_reg: id_mem_to_reg,
                     branch:     id_branch,
                     jump:       id_jump};

  // Flush wins over stall, so flush+stall still produces a bubble.
  assign insert_bubble = flush | (~stall & ~id_valid);
  assign load          = ~flush & ~stall & id_valid;

  // Bubbles zero everything, including indices, so forwarding never matches
  // and ex_valid=0 always comes with all side-effect controls cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_ctrl   <= ID_EX_CTRL_BUBBLE;
    end else if (insert_bubble) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ex_rd     <= '0;
      ex_funct3 <= '0;
      ex_funct7 <= '0;
      ex_ctrl   <= ID_EX_CTRL_BUBBLE;
    end else if (load) begin
      ex_valid  <= 1'b1;
      ex_pc     <= id_pc;
      ex_rd1    <= id_rd1;
      ex_rd2    <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs1    <= id_rs1;
      ex_rs2    <= id_rs2;
      ex_rd     <= id_rd;
      ex_funct3 <= id_funct3;
      ex_funct7 <= id_funct7;
      ex_ctrl   <= id_ctrl;
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_jump       = ex_ctrl.jump;

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (insert_bubble),
    .count (bubble_count)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - scoreboard bench for id_ex_stage_reg
module tb_id_ex_stage_reg;
  import riscv_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
  } bundle_t;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    stall = 1'b0;
  logic    flush = 1'b0;
  bundle_t in_b = '0;
  bundle_t out_b;

  logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, ex_jump;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_alu_op;
  logic [3:0]  bubble_count;

  int checks = 0;
  int errors = 0;

  bundle_t    exp_q[$];
  logic [3:0] cnt_q[$];
  string      nm_q[$];
  bundle_t    exp_state = '0;
  logic [3:0] exp_cnt = 4'd0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(in_b.valid), .id_pc(in_b.pc), .id_rd1(in_b.rd1), .id_rd2(in_b.rd2),
    .id_imm(in_b.imm), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2), .id_rd(in_b.rd),
    .id_funct3(in_b.f3), .id_funct7(in_b.f7), .id_alu_op(in_b.alu_op),
    .id_alu_src(in_b.alu_src), .id_mem_read(in_b.mem_read), .id_mem_write(in_b.mem_write),
    .id_reg_write(in_b.reg_write), .id_mem_to_reg(in_b.mem_to_reg),
    .id_branch(in_b.branch), .id_jump(in_b.jump),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .bubble_count(bubble_count)
  );

  assign out_b = {ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_funct7, ex_alu_op, ex_alu_src, ex_mem_read,
                  ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump};

  // ctrl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump}
  function automatic bundle_t mk(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                                 input logic [31:0] rd2, input logic [31:0] imm,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [1:0] op, input logic [6:0] ctrl);
    bundle_t b;
    b = {v, pc, rd1, rd2, imm, rs1, rs2, rd, f3, f7, op, ctrl};
    return b;
  endfunction

  // Monitor: one registered result per falling edge whenever something is expected.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      bundle_t    e;
      logic [3:0] c;
      string      n;
      e = exp_q.pop_front();
      c = cnt_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (out_b !== e || bubble_count !== c) begin
        errors++;
        $display("FAIL %s: got %h cnt %0d, expected %h cnt %0d", n, out_b, bubble_count, e, c);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Called at negedge+1: drive one cycle of ID/control, queue the expected EX
  // state after the next rising edge, and return at the following negedge+1.
  task automatic step(input bundle_t b, input logic st, input logic fl, input string nm);
    in_b  = b;
    stall = st;
    flush = fl;
    if (fl || (!st && !b.valid)) begin
      exp_state = '0;
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    end else if (!st) begin
      exp_state = b;
    end
    exp_q.push_back(exp_state);
    cnt_q.push_back(exp_cnt);
    nm_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  bundle_t v;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    exp_q.push_back('0); cnt_q.push_back(4'd0); nm_q.push_back("reset_init");
    @(negedge clk);
    #1;
    reset = 1'b0;

    // 1: reset mid-stream acts without waiting for a clock
    step(mk(1, 32'h100, 32'h11, 32'h22, 32'h4, 5'd1, 5'd2, 5'd3, 3'b000, 7'b0100000,
            ALUOP_RI, 7'b0001000), 0, 0, "t1_load");
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t1_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("t1_rst_pc", ex_pc, 32'd0);
    chk("t1_rst_aluop", {30'd0, ex_alu_op}, 32'd0);
    chk("t1_rst_f7", {25'd0, ex_funct7}, 32'd0);
    chk("t1_rst_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("t1_rst_cnt", {28'd0, bubble_count}, 32'd0);
    exp_state = '0;
    exp_cnt   = 4'd0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    // 2: normal flow
    step(mk(1, 32'h40, 32'h5, 32'h3, 32'hFFFF_FFF0, 5'd1, 5'd2, 5'd7, 3'b100, 7'd0,
            ALUOP_RI, 7'b0001000), 0, 0, "t2_load");
    chk("t2_pc", ex_pc, 32'h40);
    chk("t2_rd", {27'd0, ex_rd}, 32'd7);
    chk("t2_aluop", {30'd0, ex_alu_op}, 32'd2);
    chk("t2_f3", {29'd0, ex_funct3}, 32'd4);
    chk("t2_valid", {31'd0, ex_valid}, 32'd1);
    chk("t2_cnt", {28'd0, bubble_count}, 32'd0);

    // 3: stall holds for several cycles while ID changes
    step(mk(1, 32'h44, 32'h1, 32'h2, 32'h8, 5'd4, 5'd5, 5'd6, 3'b010, 7'd0,
            ALUOP_MEM, 7'b1100100), 0, 0, "t3_load44");
    v = mk(1, 32'h48, 32'h9, 32'hA, 32'hC, 5'd8, 5'd9, 5'd10, 3'b001, 7'd0,
           ALUOP_BRANCH, 7'b0000010);
    for (int i = 0; i < 3; i++) begin
      step(v, 1, 0, "t3_stall");
      chk("t3_hold_pc", ex_pc, 32'h44);
    end
    step(v, 0, 0, "t3_release");
    chk("t3_after_pc", ex_pc, 32'h48);

    // 4: flush together with stall gives a bubble
    step(mk(1, 32'h50, 32'h7, 32'h8, 32'h0, 5'd11, 5'd12, 5'd13, 3'b000, 7'd0,
            ALUOP_RI, 7'b0001000), 0, 0, "t4_load50");
    chk("t4_regwr_before", {31'd0, ex_reg_write}, 32'd1);
    step(v, 1, 1, "t4_flush_stall");
    chk("t4_valid", {31'd0, ex_valid}, 32'd0);
    chk("t4_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("t4_aluop", {30'd0, ex_alu_op}, 32'd0);
    chk("t4_rd", {27'd0, ex_rd}, 32'd0);
    chk("t4_cnt", {28'd0, bubble_count}, 32'd1);

    // 5: ID empty with side-effect controls set still loads a bubble
    step(v, 0, 0, "t5_reload");
    step(mk(0, 32'h60, 32'h1, 32'h1, 32'h1, 5'd9, 5'd9, 5'd9, 3'b111, 7'd1,
            ALUOP_JLUI, 7'b0011000), 0, 0, "t5_invalid");
    chk("t5_valid", {31'd0, ex_valid}, 32'd0);
    chk("t5_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("t5_memwr", {31'd0, ex_mem_write}, 32'd0);
    chk("t5_rd", {27'd0, ex_rd}, 32'd0);
    chk("t5_cnt", {28'd0, bubble_count}, 32'd2);

    // Plain flush, then a stall holding both the bubble and the count
    step(v, 0, 0, "x_reload");
    step(v, 0, 1, "x_flush");
    step(v, 1, 0, "x_stall_bubble");
    chk("x_cnt_hold", {28'd0, bubble_count}, 32'd3);

    // 6: saturation at 4'hF
    for (int i = 0; i < 20; i++) step(v, 0, 1, "t6_flush");
    chk("t6_sat", {28'd0, bubble_count}, 32'd15);
    step(v, 0, 1, "t6_flush_more");
    chk("t6_no_wrap", {28'd0, bubble_count}, 32'd15);
    step(v, 0, 0, "t6_load_after");
    chk("t6_load_valid", {31'd0, ex_valid}, 32'd1);
    chk("t6_load_cnt", {28'd0, bubble_count}, 32'd15);

    // Every queued expectation must have been consumed by the monitor.
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
